// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for PISO transmit control: FSM states and default frame timing.
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } tx_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BIT_DIV = 4;

endpackage : piso_ctrl_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    // Scan from the farthest offset down so the nearest request to the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        grant_idx_o = IDX_W'(idx);
        any_o       = 1'b1;
      end
    end
    if (any_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule : rr_arbiter

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one shared PISO: accepts a byte, loads it,
// paces DATA_W shifts at BIT_DIV clocks per bit, then holds the last bit one period.
module piso_tx_scheduler
  import piso_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BIT_DIV = DEF_BIT_DIV,
  parameter int OWN_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      sr_load,
  output logic                      sr_shift,
  output logic [DATA_W-1:0]         sr_data,
  output logic                      tx_active,
  output logic [OWN_W-1:0]          tx_owner,
  output logic                      frame_done
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [OWN_W-1:0] PTR_LAST = OWN_W'(NUM_REQ - 1);

  tx_state_e          state_q, state_d;
  logic [OWN_W-1:0]   ptr_q, ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic [NUM_REQ-1:0] grant;
  logic [OWN_W-1:0]   grant_idx;
  logic               grant_any;
  logic               div_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign div_last = (div_q == DIV_LAST);
  // The hold register only changes on accept, so it doubles as the PISO's parallel data.
  assign sr_data  = hold_q;
  assign tx_owner = owner_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    bit_d      = bit_q;
    div_d      = div_q;
    req_ready  = '0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    tx_active  = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          hold_d    = req_data[grant_idx*DATA_W +: DATA_W];
          owner_d   = grant_idx;
          ptr_d     = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        sr_load   = 1'b1;
        tx_active = 1'b1;
        bit_d     = '0;
        div_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        tx_active = 1'b1;
        div_d     = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          sr_shift = 1'b1;
          bit_d    = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = TAIL;
        end
      end
      TAIL: begin
        tx_active = 1'b1;
        div_d     = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

endmodule : piso_tx_scheduler

// File: tb/tb_piso_tx_scheduler.sv
// Randomised bench for piso_tx_scheduler at BIT_DIV=4 and BIT_DIV=1, checked every
// cycle against a frame-timeline model driven by cycles-since-accept arithmetic.
module tb_piso_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 2;

  localparam int M_NONE = 0;
  localparam int M_RR   = 1;
  localparam int M_RAND = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]    valid  [2];
  logic [N*DW-1:0] data   [2];
  logic [N-1:0]    ready  [2];
  logic            load   [2];
  logic            shift  [2];
  logic [DW-1:0]   sdata  [2];
  logic            active [2];
  logic [OW-1:0]   owner  [2];
  logic            done   [2];
  logic [DW-1:0]   piso   [2];

  int tests = 0;
  int fails = 0;

  // Model state per DUT: busy frame, cycles since accept, pointer, owner, byte.
  int            m_busy  [2];
  int            m_c     [2];
  int            m_ptr   [2];
  int            m_owner [2];
  logic [DW-1:0] m_byte  [2];
  bit            acc     [2][N];
  bit            pend_v  [2][N];
  logic [DW-1:0] pend_d  [2][N];

  always #5 clk = ~clk;

  piso_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .BIT_DIV(4), .OWN_W(OW)) u_dut_div4 (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_data(data[0]),
    .req_ready(ready[0]), .sr_load(load[0]), .sr_shift(shift[0]), .sr_data(sdata[0]),
    .tx_active(active[0]), .tx_owner(owner[0]), .frame_done(done[0]));

  piso_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .BIT_DIV(1), .OWN_W(OW)) u_dut_div1 (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_data(data[1]),
    .req_ready(ready[1]), .sr_load(load[1]), .sr_shift(shift[1]), .sr_data(sdata[1]),
    .tx_active(active[1]), .tx_owner(owner[1]), .frame_done(done[1]));

  // Behavioural PISO sharing the scheduler's reset; MSB leaves first.
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset)         piso[d] <= '0;
      else if (load[d])  piso[d] <= sdata[d];
      else if (shift[d]) piso[d] <= {piso[d][DW-2:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_c[d] = 0; m_ptr[d] = 0; m_owner[d] = 0; m_byte[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    int bd, last, w, k;
    logic [N-1:0] er;
    logic el, es, ed;
    bd   = (d == 0) ? 4 : 1;
    last = 1 + (DW + 1) * bd;
    w    = -1;
    er   = '0;
    if (m_busy[d] == 0)
      for (int i = 0; i < N; i++) begin
        if (w < 0 && valid[d][(m_ptr[d] + i) % N]) w = (m_ptr[d] + i) % N;
      end
    if (w >= 0) er[w] = 1'b1;
    el = (m_busy[d] != 0) && (m_c[d] == 1);
    es = (m_busy[d] != 0) && (m_c[d] >= 2) && (m_c[d] <= 1 + DW * bd) && ((m_c[d] - 1) % bd == 0);
    ed = (m_busy[d] != 0) && (m_c[d] == last);
    check($sformatf("d%0d req_ready", d),  ready[d],  er);
    check($sformatf("d%0d sr_load", d),    load[d],   el);
    check($sformatf("d%0d sr_shift", d),   shift[d],  es);
    check($sformatf("d%0d frame_done", d), done[d],   ed);
    check($sformatf("d%0d tx_active", d),  active[d], m_busy[d] != 0);
    check($sformatf("d%0d tx_owner", d),   owner[d],  m_owner[d]);
    check($sformatf("d%0d sr_data", d),    sdata[d],  m_byte[d]);
    if (es) begin
      k = (m_c[d] - 1) / bd;
      check($sformatf("d%0d serial_bit%0d", d, k), piso[d][DW-1], m_byte[d][DW-k]);
    end
    if (m_busy[d] != 0) begin
      if (m_c[d] == last) m_busy[d] = 0;
      else m_c[d]++;
    end else if (w >= 0) begin
      m_busy[d]  = 1;
      m_c[d]     = 1;
      m_owner[d] = w;
      m_ptr[d]   = (w + 1) % N;
      m_byte[d]  = data[d][w*DW +: DW];
      acc[d][w]  = 1'b1;
    end
  endtask

  task automatic apply_stim(input int mode);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        if (acc[d][i]) begin valid[d][i] = 1'b0; acc[d][i] = 1'b0; end
        if (pend_v[d][i]) begin
          valid[d][i] = 1'b1; data[d][i*DW +: DW] = pend_d[d][i]; pend_v[d][i] = 1'b0;
        end
        if (mode == M_RR) begin
          valid[d][i] = 1'b1; data[d][i*DW +: DW] = DW'(8'h10 + i);
        end else if (mode == M_RAND && !valid[d][i] && $urandom_range(7) == 0) begin
          valid[d][i] = 1'b1; data[d][i*DW +: DW] = DW'($urandom);
        end
      end
  endtask

  task automatic cycle(input int mode);
    @(posedge clk); #1;
    apply_stim(mode);
    @(negedge clk);
    model_step(0);
    model_step(1);
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) cycle(mode);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0;
      for (int i = 0; i < N; i++) acc[d][i] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk); #1;
    reset = 1'b0;
    apply_stim(M_NONE);
    @(negedge clk);
    model_step(0);
    model_step(1);
  endtask

  task automatic post(input int i, input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    pend_v[0][i] = 1'b1; pend_d[0][i] = b0;
    pend_v[1][i] = 1'b1; pend_d[1][i] = b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0;
      data[d]  = '0;
      for (int i = 0; i < N; i++) begin acc[d][i] = 1'b0; pend_v[d][i] = 1'b0; pend_d[d][i] = '0; end
    end
    model_reset();
    do_reset();

    // Single frame: requester 2, A5 at BIT_DIV=4 and FF at BIT_DIV=1.
    post(2, 8'hA5, 8'hFF);
    run(M_NONE, 45);
    check("single owner", owner[0], 2);

    // Quiet line.
    run(M_NONE, 20);

    // All four requesters continuously valid.
    run(M_RR, 5 * 38 + 2);
    do_reset();

    // Pointer wrap: grant 2 leaves pointer at 3, then 3 beats 0.
    post(2, 8'h33, 8'h33);
    run(M_NONE, 40);
    post(0, 8'h40, 8'h40);
    post(3, 8'h43, 8'h43);
    run(M_NONE, 90);

    // Reset mid-SHIFT after three shift pulses.
    post(1, 8'h5A, 8'h5A);
    for (int i = 0; i < 60; i++) begin
      cycle(M_NONE);
      if (m_busy[0] != 0 && m_c[0] == 2 + 3 * 4) break;
    end
    check("reach mid-shift", m_c[0], 2 + 3 * 4);
    do_reset();
    post(0, 8'hC3, 8'hC3);
    post(2, 8'h3C, 8'h3C);
    run(M_NONE, 90);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else cycle(M_RAND);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_piso_tx_scheduler

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit PISO shift register among NUM_REQ byte requesters.
- Accepts one byte per frame over a valid/ready handshake, then drives the PISO's load, shift and parallel-data inputs.
- Paces shifts at one bit per BIT_DIV clocks and signals frame completion.
- Sits between the requester blocks and the PISO; the PISO's serial output is the line output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must equal the PISO width.
- BIT_DIV, 4, clocks per serial bit (>=1).
- OWN_W, 2, width of tx_owner; equals clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept; transfer occurs when valid&ready.
- sr_load  output  1  PISO parallel-load strobe.
- sr_shift  output  1  PISO shift strobe.
- sr_data  output  DATA_W  PISO parallel data.
- tx_active  output  1  high from load cycle through frame_done cycle.
- tx_owner  output  OWN_W  index of the current or last granted requester.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: state IDLE; req_ready, sr_load, sr_shift, tx_active and frame_done are 0; sr_data=0; tx_owner=0; rr pointer=0; counters=0.
- Reset mid-frame aborts with no frame_done. The PISO shares the same reset.
- States: IDLE, LOAD, SHIFT, TAIL.
- IDLE:
  - If any req_valid, winner w is the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[w]=1 combinationally in that cycle; the byte is captured into a hold register.
  - tx_owner<=w; pointer<=(w+1) mod NUM_REQ; next state LOAD.
  - req_ready is 0 in all other states.
- LOAD (1 cycle):
  - sr_load=1 and sr_data=held byte; tx_active=1.
  - bit counter<=0, divider<=0; next state SHIFT.
- SHIFT:
  - Divider counts 0..BIT_DIV-1 and wraps.
  - sr_shift=1 exactly in cycles where divider==BIT_DIV-1.
  - After the DATA_W-th shift pulse, divider<=0 and next state TAIL.
- TAIL:
  - Holds the last bit for one more bit period.
  - frame_done=1 in the cycle divider==BIT_DIV-1, then IDLE.
- Timing, accept at cycle 0:
  - load at cycle 1.
  - shift k (1..DATA_W) at cycle 1+k*BIT_DIV.
  - frame_done at cycle 1+(DATA_W+1)*BIT_DIV.
  - next accept possible one cycle later.
- sr_load and sr_shift are never high together. sr_data holds its value outside LOAD.
- Requester rule: req_valid and req_data stay stable until accepted. The bench asserts this; RTL does not check it.
- BIT_DIV=1: a shift pulse every SHIFT cycle; TAIL lasts 1 cycle.
- A single requester continuously valid is re-granted every frame. No starvation: each valid requester is granted within NUM_REQ frames.

Decomposition:
- Shared package piso_ctrl_pkg holds the state enum (IDLE, LOAD, SHIFT, TAIL) and the default DATA_W/BIT_DIV constants.
- One sub-module: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant and index out), combinational, reused by other shared-resource blocks.

Test Plan:
- Single frame: reset, req_valid[2]=1, data 8'hA5, BIT_DIV=4 -> req_ready[2] at cycle 0, sr_load with sr_data=A5 at cycle 1, shifts at 5,9,...,33, PISO serial_out sequence 1,0,1,0,0,1,0,1, frame_done at 37, tx_owner=2.
- Round robin: all four valid continuously with data 8'h10..8'h13 -> grant order 0,1,2,3,0; each frame 37 cycles apart plus 1 idle cycle.
- Pointer wrap: pointer=3 after granting 2, only req 0 and 3 valid -> grant 3, then 0.
- BIT_DIV=1, data 8'hFF -> shifts on 8 consecutive cycles 2..9, frame_done at cycle 10, serial_out high for 8 bits.
- Reset mid-SHIFT after 3 pulses -> all outputs 0 in the same cycle, no frame_done, next grant starts from requester 0.
- No valid for 20 cycles -> state stays IDLE, req_ready=0, no load or shift strobes.
